// File: rtl/kws_posterior_smoother.sv
// -----------------------------------------------------------------------------
// kws_posterior_smoother
// Decision stage behind the keyword-spotting classifier. Keeps the last WIN_LEN
// score vectors in a ring, maintains a running per-class sum, runs a serial
// argmax over the averaged (or raw, in bypass) scores, then applies a threshold,
// a filler-class exclusion and a hold-off before emitting a detection pulse.
//
// Ports
//   clk            clock, rising edge
//   rst_n          synchronous reset, active HIGH (1 = reset)
//   scores_in      NUM_KEYWORDS packed unsigned scores, class k at [k*SCORE_BITS +: SCORE_BITS]
//   scores_valid   scores_in valid
//   scores_ready   vector can be accepted (high only while idle)
//   threshold      minimum score for a detection (sampled in UPDATE)
//   bypass         1 = decide on the newest vector only (sampled in UPDATE)
//   clear          synchronous flush of window and hold-off state
//   kw_valid       one-cycle detection pulse
//   kw_idx         index of the last detected keyword
//   kw_score       score of the last detected keyword
//   kw_suppressed  one-cycle pulse: detection blocked only by hold-off
// -----------------------------------------------------------------------------
module kws_posterior_smoother #(
  parameter int NUM_KEYWORDS = 10,
  parameter int SCORE_BITS   = 8,
  parameter int WIN_LEN      = 4,
  parameter int HOLDOFF      = 8,
  parameter int FILLER_IDX   = 0,
  parameter int IDX_BITS     = (NUM_KEYWORDS > 1) ? $clog2(NUM_KEYWORDS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_KEYWORDS*SCORE_BITS-1:0] scores_in,
  input  logic                               scores_valid,
  output logic                               scores_ready,
  input  logic [SCORE_BITS-1:0]              threshold,
  input  logic                               bypass,
  input  logic                               clear,
  output logic                               kw_valid,
  output logic [IDX_BITS-1:0]                kw_idx,
  output logic [SCORE_BITS-1:0]              kw_score,
  output logic                               kw_suppressed
);

  localparam int SHIFT     = $clog2(WIN_LEN);
  localparam int SUM_BITS  = SCORE_BITS + SHIFT;
  localparam int VEC_BITS  = NUM_KEYWORDS * SCORE_BITS;
  localparam int PTR_BITS  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int FILL_BITS = $clog2(WIN_LEN + 1);
  localparam int HOLD_BITS = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SCAN   = 2'd2,
    ST_DECIDE = 2'd3
  } state_t;

  state_t                  state_r;
  logic [VEC_BITS-1:0]     new_vec_r;
  logic [VEC_BITS-1:0]     ring_r [WIN_LEN];
  logic [SUM_BITS-1:0]     sum_r  [NUM_KEYWORDS];
  logic [FILL_BITS-1:0]    fill_cnt_r;
  logic [PTR_BITS-1:0]     wr_ptr_r;
  logic [HOLD_BITS-1:0]    holdoff_cnt_r;
  logic                    hold_busy_r;
  logic                    bypass_r;
  logic [SCORE_BITS-1:0]   threshold_r;
  logic [IDX_BITS-1:0]     scan_k_r;
  logic [SCORE_BITS-1:0]   best_val_r;
  logic [IDX_BITS-1:0]     best_idx_r;

  logic                    fill_full_s;
  logic [SCORE_BITS-1:0]   scan_val_s;
  logic                    det_s;

  // Candidate value for the class currently being scanned plus the detection condition.
  always_comb begin
    fill_full_s = (fill_cnt_r == FILL_BITS'(WIN_LEN));
    // Top SCORE_BITS of the sum are exactly sum >> log2(WIN_LEN).
    scan_val_s  = bypass_r ? new_vec_r[scan_k_r*SCORE_BITS +: SCORE_BITS]
                           : sum_r[scan_k_r][SUM_BITS-1 -: SCORE_BITS];
    det_s       = (bypass_r | fill_full_s) &
                  (best_idx_r != IDX_BITS'(FILLER_IDX)) &
                  (best_val_r >= threshold_r);
  end

  // Ring storage: written once per accepted vector, never cleared.
  always_ff @(posedge clk) begin
    if (!rst_n && !clear && (state_r == ST_UPDATE)) begin
      ring_r[wr_ptr_r] <= new_vec_r;
    end
  end

  // Control FSM, running sums, hold-off and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r       <= ST_IDLE;
      new_vec_r     <= '0;
      fill_cnt_r    <= '0;
      wr_ptr_r      <= '0;
      holdoff_cnt_r <= '0;
      hold_busy_r   <= 1'b0;
      bypass_r      <= 1'b0;
      threshold_r   <= '0;
      scan_k_r      <= '0;
      best_val_r    <= '0;
      best_idx_r    <= '0;
      scores_ready  <= 1'b1;
      kw_valid      <= 1'b0;
      kw_suppressed <= 1'b0;
      kw_idx        <= '0;
      kw_score      <= '0;
      for (int k = 0; k < NUM_KEYWORDS; k++) begin
        sum_r[k] <= '0;
      end
    end else if (clear) begin
      // Flush drops any vector in flight; last detection stays visible.
      state_r       <= ST_IDLE;
      fill_cnt_r    <= '0;
      wr_ptr_r      <= '0;
      holdoff_cnt_r <= '0;
      hold_busy_r   <= 1'b0;
      scores_ready  <= 1'b1;
      kw_valid      <= 1'b0;
      kw_suppressed <= 1'b0;
      for (int k = 0; k < NUM_KEYWORDS; k++) begin
        sum_r[k] <= '0;
      end
    end else begin
      kw_valid      <= 1'b0;
      kw_suppressed <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (scores_valid && scores_ready) begin
            new_vec_r    <= scores_in;
            scores_ready <= 1'b0;
            state_r      <= ST_UPDATE;
          end else begin
            scores_ready <= 1'b1;
          end
        end

        ST_UPDATE: begin
          // Until the window is full the slot being overwritten holds no live data.
          for (int k = 0; k < NUM_KEYWORDS; k++) begin
            sum_r[k] <= sum_r[k]
                      + SUM_BITS'(new_vec_r[k*SCORE_BITS +: SCORE_BITS])
                      - (fill_full_s ? SUM_BITS'(ring_r[wr_ptr_r][k*SCORE_BITS +: SCORE_BITS])
                                     : SUM_BITS'(0));
          end
          wr_ptr_r <= (wr_ptr_r == PTR_BITS'(WIN_LEN - 1)) ? PTR_BITS'(0)
                                                           : wr_ptr_r + PTR_BITS'(1);
          if (!fill_full_s) begin
            fill_cnt_r <= fill_cnt_r + FILL_BITS'(1);
          end
          // Hold-off gates this vector on the count as it stood on arrival,
          // so HOLDOFF full vectors are suppressed after a detection.
          hold_busy_r <= (holdoff_cnt_r != HOLD_BITS'(0));
          if (holdoff_cnt_r != HOLD_BITS'(0)) begin
            holdoff_cnt_r <= holdoff_cnt_r - HOLD_BITS'(1);
          end
          bypass_r    <= bypass;
          threshold_r <= threshold;
          scan_k_r    <= '0;
          state_r     <= ST_SCAN;
        end

        ST_SCAN: begin
          // Strict '>' keeps the lowest index on ties; class 0 seeds the search.
          if ((scan_k_r == IDX_BITS'(0)) || (scan_val_s > best_val_r)) begin
            best_val_r <= scan_val_s;
            best_idx_r <= scan_k_r;
          end
          if (scan_k_r == IDX_BITS'(NUM_KEYWORDS - 1)) begin
            state_r <= ST_DECIDE;
          end else begin
            scan_k_r <= scan_k_r + IDX_BITS'(1);
          end
        end

        ST_DECIDE: begin
          if (det_s && !hold_busy_r) begin
            kw_valid      <= 1'b1;
            kw_idx        <= best_idx_r;
            kw_score      <= best_val_r;
            holdoff_cnt_r <= HOLD_BITS'(HOLDOFF);
          end else if (det_s) begin
            kw_suppressed <= 1'b1;
          end
          scores_ready <= 1'b1;
          state_r      <= ST_IDLE;
        end

        default: begin
          scores_ready <= 1'b1;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kws_posterior_smoother.sv
// -----------------------------------------------------------------------------
// tb_kws_posterior_smoother
// Scoreboard bench: every vector sent is run through a behavioural model of the
// decision stage and the expected outcome is queued; when the DUT finishes the
// vector (pulse or ready return) the entry is popped and compared.
// -----------------------------------------------------------------------------
module tb_kws_posterior_smoother;

  localparam int N  = 10;
  localparam int SB = 8;
  localparam int W  = 4;
  localparam int HO = 8;

  logic            clk;
  logic            rst_n;
  logic [N*SB-1:0] scores_in;
  logic            scores_valid;
  logic            scores_ready;
  logic [SB-1:0]   threshold;
  logic            bypass;
  logic            clear;
  logic            kw_valid;
  logic [3:0]      kw_idx;
  logic [SB-1:0]   kw_score;
  logic            kw_suppressed;

  kws_posterior_smoother dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scores_in    (scores_in),
    .scores_valid (scores_valid),
    .scores_ready (scores_ready),
    .threshold    (threshold),
    .bypass       (bypass),
    .clear        (clear),
    .kw_valid     (kw_valid),
    .kw_idx       (kw_idx),
    .kw_score     (kw_score),
    .kw_suppressed(kw_suppressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;   // 0 = no pulse, 1 = kw_valid, 2 = kw_suppressed
    int idx;    // expected held kw_idx
    int score;  // expected held kw_score
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_cnt = 0;

  // Reference model state
  logic [N*SB-1:0] m_ring [W];
  int m_sum [N];
  int m_fill, m_wr, m_hold, m_last_idx, m_last_score;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [N*SB-1:0] mk(input int k, input int v);
    logic [N*SB-1:0] r;
    logic [31:0] vv;
    r  = '0;
    vv = v;
    r[k*SB +: SB] = vv[SB-1:0];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) m_sum[k] = 0;
    m_fill = 0;
    m_wr   = 0;
    m_hold = 0;
  endtask

  task automatic model_step(input logic [N*SB-1:0] v, input logic byp, input int thr,
                            output exp_t e);
    int pre, bi, bv, val;
    bit det;
    for (int k = 0; k < N; k++) begin
      m_sum[k] += int'(v[k*SB +: SB]);
      if (m_fill == W) m_sum[k] -= int'(m_ring[m_wr][k*SB +: SB]);
    end
    m_ring[m_wr] = v;
    m_wr = (m_wr + 1) % W;
    if (m_fill < W) m_fill++;
    pre = m_hold;
    if (m_hold > 0) m_hold--;
    bi = 0;
    bv = 0;
    for (int k = 0; k < N; k++) begin
      val = byp ? int'(v[k*SB +: SB]) : (m_sum[k] / W);
      if (k == 0 || val > bv) begin
        bv = val;
        bi = k;
      end
    end
    det = (byp || m_fill == W) && (bi != 0) && (bv >= thr);
    e.kind = 0;
    if (det && pre == 0) begin
      e.kind = 1;
      m_last_idx = bi;
      m_last_score = bv;
      m_hold = HO;
    end else if (det) begin
      e.kind = 2;
    end
    e.idx = m_last_idx;
    e.score = m_last_score;
  endtask

  // Count handshakes the DUT actually takes.
  always @(posedge clk) begin
    if (!rst_n && !clear && scores_valid && scores_ready) acc_cnt <= acc_cnt + 1;
  end

  // Send one vector, keeping valid high for 'hold' cycles after acceptance,
  // then check the outcome against the scoreboard.
  task automatic send_vec(input logic [N*SB-1:0] v, input int hold);
    exp_t e;
    exp_t got;
    int w, n;
    model_step(v, bypass, int'(threshold), e);
    sb_q.push_back(e);
    @(negedge clk);
    scores_in = v;
    scores_valid = 1'b1;
    w = 0;
    while (!scores_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!scores_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      scores_valid = 1'b0;
      void'(sb_q.pop_front());
      return;
    end
    @(posedge clk);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n > hold) scores_valid = 1'b0;
      if (kw_valid || kw_suppressed || scores_ready) break;
    end
    scores_valid = 1'b0;
    got = sb_q.pop_front();
    chk("latency",       n - 1,         32'd12);
    chk("kw_valid",      kw_valid,      (got.kind == 1));
    chk("kw_suppressed", kw_suppressed, (got.kind == 2));
    chk("kw_idx",        kw_idx,        got.idx);
    chk("kw_score",      kw_score,      got.score);
    chk("ready_back",    scores_ready,  32'd1);
    @(negedge clk);
    chk("pulse_len",     {kw_valid, kw_suppressed}, 32'd0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, pulses;
    rst_n = 1'b1;
    clear = 1'b0;
    scores_valid = 1'b0;
    scores_in = '0;
    bypass = 1'b0;
    threshold = '0;
    model_clear();
    m_last_idx = 0;
    m_last_score = 0;
    for (int i = 0; i < W; i++) m_ring[i] = '0;

    // 1 Reset
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    chk("rst_ready",     scores_ready,  32'd1);
    chk("rst_valid",     kw_valid,      32'd0);
    chk("rst_supp",      kw_suppressed, 32'd0);
    chk("rst_idx",       kw_idx,        32'd0);
    chk("rst_score",     kw_score,      32'd0);

    // 2 Fill, 3 Hold-off
    threshold = 8'd100;
    for (int i = 0; i < 4 + 9; i++) send_vec(mk(3, 200), 0);

    // 4 Ties, then filler winning the argmax
    do_clear();
    for (int i = 0; i < 4; i++) send_vec(mk(2, 150) | mk(7, 150), 0);
    do_clear();
    for (int i = 0; i < 4; i++) send_vec(mk(0, 250) | mk(5, 200), 0);

    // 5 Sliding average with truncation: 510/4 = 127
    threshold = 8'd128;
    do_clear();
    send_vec(mk(4, 255), 0);
    send_vec(mk(4, 255), 0);
    send_vec('0, 0);
    send_vec('0, 0);
    threshold = 8'd127;
    do_clear();
    send_vec(mk(4, 255), 0);
    send_vec(mk(4, 255), 0);
    send_vec('0, 0);
    send_vec('0, 0);

    // 6a Clear during SCAN drops the vector
    do_clear();
    @(negedge clk);
    scores_in = mk(5, 220);
    scores_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    scores_valid = 1'b0;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    chk("clr_scan_ready", scores_ready, 32'd1);
    chk("clr_scan_valid", kw_valid,     32'd0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (kw_valid || kw_suppressed) pulses++;
    end
    chk("clr_scan_nopulse", pulses, 32'd0);

    // 6b clear together with valid in IDLE wins
    a0 = acc_cnt;
    @(negedge clk);
    scores_in = mk(5, 220);
    scores_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    scores_valid = 1'b0;
    clear = 1'b0;
    model_clear();
    chk("clr_vs_valid_acc", acc_cnt - a0, 32'd0);
    chk("clr_vs_valid_ready", scores_ready, 32'd1);

    // 6c Bypass on a single vector
    bypass = 1'b1;
    threshold = 8'd90;
    send_vec(mk(6, 90), 0);

    // 6d valid held while busy is taken once
    a0 = acc_cnt;
    send_vec(mk(6, 90), 10);
    chk("held_valid_acc", acc_cnt - a0, 32'd1);
    bypass = 1'b0;

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
